// File: rtl/tdc_measurement_controller_if.sv
// Host-side bundle of a TDC measurement controller: measurement control,
// stop strobe with thermometer sample, and the result FIFO read port.
interface tdc_measurement_controller_if #(
    parameter int unsigned COARSE_W   = 16,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic                arm;
    logic                abort;
    logic                hit;
    logic [31:0]         thermo;
    logic [COARSE_W-1:0] window;
    logic [COARSE_W+5:0] dout;
    logic                dout_valid;
    logic                dout_ready;
    logic                busy;
    logic [LVL_W-1:0]    fifo_level;
    logic                overflow;
    logic                clear_ovf;

    // Host / stimulus side.
    modport master (
        output arm, abort, hit, thermo, window, dout_ready, clear_ovf,
        input  dout, dout_valid, busy, fifo_level, overflow
    );

    // Controller side.
    modport slave (
        input  arm, abort, hit, thermo, window, dout_ready, clear_ovf,
        output dout, dout_valid, busy, fifo_level, overflow
    );
endinterface

// File: rtl/tdc_measurement_controller.sv
// Single-shot TDC measurement controller: coarse cycle counter started by arm,
// stopped by hit (fine value = popcount of the thermometer sample) or by the
// window timeout, with results queued in a first-word-fall-through FIFO.
// FIFO_DEPTH must be a power of two, at least 2.
module tdc_measurement_controller #(
    parameter int unsigned COARSE_W   = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic                         clk,
    input logic                         rst_n,
    tdc_measurement_controller_if.slave bus
);
    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = AW + 1;
    localparam int unsigned ENT_W = COARSE_W + 6;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ARMED  = 2'd1;
    localparam logic [1:0] ENCODE = 2'd2;
    localparam logic [1:0] PUSH   = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [COARSE_W-1:0] coarse_q, coarse_d;
    logic [31:0]         thermo_q, thermo_d;
    logic [ENT_W-1:0]    entry_q, entry_d;
    logic [ENT_W-1:0]    mem_q [FIFO_DEPTH];
    logic [ENT_W-1:0]    mem_d [FIFO_DEPTH];
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic                ovf_q, ovf_d;

    logic [COARSE_W-1:0] win_m1;
    logic                timeout;
    logic [5:0]          ones;
    logic [4:0]          fine;
    logic                fifo_empty, fifo_full;
    logic                pop, push_req, push;

    assign win_m1  = bus.window - COARSE_W'(1);
    assign timeout = (bus.window != '0) && (coarse_q == win_m1);

    // Fine code: count every one in the sample, bubbles included, saturate at 31.
    always_comb begin
        ones = '0;
        for (int i = 0; i < 32; i++) begin
            ones = ones + {5'd0, thermo_q[i]};
        end
        fine = ones[5] ? 5'd31 : ones[4:0];
    end

    // Measurement FSM; abort beats hit, hit beats timeout.
    always_comb begin
        state_d  = state_q;
        coarse_d = coarse_q;
        thermo_d = thermo_q;
        entry_d  = entry_q;
        case (state_q)
            IDLE: begin
                if (bus.arm) begin
                    state_d  = ARMED;
                    coarse_d = '0;
                end
            end
            ARMED: begin
                coarse_d = coarse_q + COARSE_W'(1);
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.hit) begin
                    thermo_d = bus.thermo;
                    entry_d  = {1'b0, coarse_q, 5'd0};
                    state_d  = ENCODE;
                end else if (timeout) begin
                    entry_d = {1'b1, bus.window, 5'd0};
                    state_d = PUSH;
                end
            end
            ENCODE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    entry_d[4:0] = fine;
                    state_d      = PUSH;
                end
            end
            PUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
    assign pop        = !fifo_empty && bus.dout_ready;
    assign push_req   = (state_q == PUSH);
    // A pop in the same cycle frees the slot the push needs.
    assign push       = push_req && (!fifo_full || pop);

    // FIFO pointers, occupancy, storage and sticky overflow (set beats clear).
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q;
        if (push) begin
            mem_d[wr_ptr_q] = entry_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!push && pop) begin
            level_d = level_q - LVL_W'(1);
        end
        if (push_req && !push) begin
            ovf_d = 1'b1;
        end else if (bus.clear_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            coarse_q <= '0;
            thermo_q <= '0;
            entry_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            coarse_q <= coarse_d;
            thermo_q <= thermo_d;
            entry_q  <= entry_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
        end
    end

    // dout is forced to zero while empty so stale storage never shows.
    assign bus.dout       = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign bus.dout_valid = !fifo_empty;
    assign bus.busy       = (state_q != IDLE);
    assign bus.fifo_level = level_q;
    assign bus.overflow   = ovf_q;
endmodule

// File: tb/tb_tdc_measurement_controller.sv
// Bench for tdc_measurement_controller: each measurement's outcome is worked
// out from its schedule (abort / hit / timeout cycle), results go into a queue
// model of the FIFO, and all outputs are compared every cycle.
module tb_tdc_measurement_controller;
    localparam int unsigned CW    = 16;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned EW    = CW + 6;
    localparam int          NONE  = 1 << 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tdc_measurement_controller_if #(.COARSE_W(CW), .FIFO_DEPTH(DEPTH)) bus ();

    tdc_measurement_controller #(.COARSE_W(CW), .FIFO_DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [EW-1:0] exp_q[$];
    bit            exp_ovf  = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [4:0] fine_of(input logic [31:0] t);
        int n;
        n = $countones(t);
        return (n > 31) ? 5'd31 : 5'(n);
    endfunction

    // One clock: drive at negedge, update the queue model at posedge, compare at next negedge.
    task automatic step(input logic a_arm, input logic a_abort, input logic a_hit,
                        input logic [31:0] a_th, input logic [CW-1:0] a_win,
                        input logic a_rdy, input logic a_clr,
                        input bit do_push, input logic [EW-1:0] ent, input bit busy_exp);
        bit pop, room;
        bus.arm        = a_arm;
        bus.abort      = a_abort;
        bus.hit        = a_hit;
        bus.thermo     = a_th;
        bus.window     = a_win;
        bus.dout_ready = a_rdy;
        bus.clear_ovf  = a_clr;
        @(posedge clk);
        pop  = (exp_q.size() != 0) && a_rdy;
        room = (exp_q.size() < DEPTH) || pop;
        if (pop) void'(exp_q.pop_front());
        if (do_push && room) exp_q.push_back(ent);
        if (do_push && !room) exp_ovf = 1'b1;
        else if (a_clr) exp_ovf = 1'b0;
        @(negedge clk);
        check_eq("dout_valid", bus.dout_valid, exp_q.size() != 0);
        check_eq("fifo_level", bus.fifo_level, exp_q.size());
        if (exp_q.size() != 0) check_eq("dout", bus.dout, exp_q[0]);
        check_eq("overflow", bus.overflow, exp_ovf);
        check_eq("busy", bus.busy, busy_exp);
    endtask

    task automatic idle(input int n, input int rmode, input bit clr);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 1'b0, $urandom, '0,
                 (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'(rmode), clr, 1'b0, '0, 1'b0);
        end
    endtask

    // w applies to ARMED cycles j < sw, w2 from j >= sw. k: hit cycle (-1 none),
    // ab: abort cycle (-1 none), ab_enc: abort in ENCODE after the hit.
    // rmode: ready 0/1/random/only-in-last-cycle. cmode: clear_ovf none/last-cycle/random.
    task automatic run_meas(input logic [CW-1:0] w, input logic [CW-1:0] w2, input int sw,
                            input int k, input logic [31:0] th, input int ab, input bit ab_enc,
                            input int rmode, input int cmode);
        int            jt, kh, ka, last, kind;
        bit            push;
        logic [EW-1:0] ent;
        logic [CW-1:0] wj, wd;
        logic          a_arm, a_ab, a_hit, rdy, clr;
        jt = NONE;
        for (int j = 0; j < 400; j++) begin
            wj = (j >= sw) ? w2 : w;
            if (wj != '0 && j == int'(wj) - 1) begin
                jt = j;
                break;
            end
        end
        kh   = (k >= 0) ? k : NONE;
        ka   = (ab >= 0) ? ab : NONE;
        push = 1'b0;
        ent  = '0;
        if (ka <= kh && ka <= jt) begin
            if (ka == NONE) begin
                $display("FAIL schedule: got no terminating event expected one");
                $fatal(1);
            end
            kind = 0;
            last = 1 + ka;
        end else if (kh <= jt) begin
            kind = 1;
            last = ab_enc ? 2 + kh : 3 + kh;
            push = !ab_enc;
            ent  = {1'b0, CW'(kh), fine_of(th)};
        end else begin
            kind = 2;
            last = 2 + jt;
            push = 1'b1;
            wj   = (jt >= sw) ? w2 : w;
            ent  = {1'b1, wj, 5'd0};
        end
        for (int c = 0; c <= last; c++) begin
            a_arm = (c == 0) || ($urandom_range(0, 7) == 0);
            a_hit = (kh != NONE) && (c == 1 + kh);
            a_ab  = (kind == 0 && c == 1 + ka) || (kind == 1 && ab_enc && c == 2 + kh) ||
                    (push && c == last && $urandom_range(0, 1) == 1);
            wd    = (c >= 1 + sw) ? w2 : w;
            case (rmode)
                0:       rdy = 1'b0;
                1:       rdy = 1'b1;
                2:       rdy = 1'($urandom_range(0, 1));
                default: rdy = (c == last);
            endcase
            case (cmode)
                0:       clr = 1'b0;
                1:       clr = (c == last);
                default: clr = ($urandom_range(0, 9) == 0);
            endcase
            step(a_arm, a_ab, a_hit, a_hit ? th : $urandom, wd, rdy, clr,
                 push && (c == last), ent, (c + 1) <= last);
        end
    endtask

    task automatic pulse_reset();
        bus.arm = 1'b0; bus.abort = 1'b0; bus.hit = 1'b0;
        bus.dout_ready = 1'b0; bus.clear_ovf = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_dout_valid", bus.dout_valid, 1'b0);
        check_eq("rst_fifo_level", bus.fifo_level, 0);
        check_eq("rst_overflow", bus.overflow, 1'b0);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_dout", bus.dout, 0);
        exp_q.delete();
        exp_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [CW-1:0] w;
        int            k, ab;
        bit            ae;
        logic [31:0]   th;
        bus.arm = 1'b0; bus.abort = 1'b0; bus.hit = 1'b0; bus.thermo = '0;
        bus.window = '0; bus.dout_ready = 1'b0; bus.clear_ovf = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_dout_valid", bus.dout_valid, 1'b0);
        check_eq("rst_fifo_level", bus.fifo_level, 0);
        check_eq("rst_overflow", bus.overflow, 1'b0);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_dout", bus.dout, 0);
        rst_n = 1'b1;

        // Arm cycle 0, hit cycle 11: {0,10,11}, valid in cycle 14.
        run_meas('0, '0, NONE, 10, 32'h0000_07FF, -1, 1'b0, 1, 0);
        idle(2, 1, 1'b0);
        // Timeout with window 5.
        run_meas(16'd5, 16'd5, NONE, -1, '0, -1, 1'b0, 1, 0);
        idle(2, 1, 1'b0);
        // Saturated fine code; hit on the timeout cycle wins.
        run_meas('0, '0, NONE, 3, 32'hFFFF_FFFF, -1, 1'b0, 1, 0);
        run_meas(16'd7, 16'd7, NONE, 6, 32'h0000_00FF, -1, 1'b0, 1, 0);
        // Window lowered below the running count: no timeout; raised: later timeout.
        run_meas(16'd3, 16'd1, 1, 8, 32'h0000_000F, -1, 1'b0, 1, 0);
        run_meas(16'd3, 16'd6, 1, -1, '0, -1, 1'b0, 1, 0);
        idle(3, 1, 1'b0);

        // Overflow: 5 results without reads, clear on the dropping push (set wins).
        for (int i = 0; i < 4; i++) run_meas('0, '0, NONE, i + 1, $urandom, -1, 1'b0, 0, 0);
        run_meas('0, '0, NONE, 2, $urandom, -1, 1'b0, 0, 1);
        idle(4, 1, 1'b0);
        idle(1, 0, 1'b1);

        // Full FIFO with a pop in the PUSH cycle: nothing dropped.
        for (int i = 0; i < 4; i++) run_meas('0, '0, NONE, 2 * i, $urandom, -1, 1'b0, 0, 0);
        run_meas('0, '0, NONE, 5, $urandom, -1, 1'b0, 3, 0);
        idle(5, 1, 1'b0);

        // Aborts: in ENCODE, in ARMED, together with hit, together with timeout.
        run_meas('0, '0, NONE, 4, $urandom, -1, 1'b1, 1, 0);
        run_meas(16'd9, 16'd9, NONE, -1, '0, 3, 1'b0, 1, 0);
        run_meas('0, '0, NONE, 5, $urandom, 5, 1'b0, 1, 0);
        run_meas(16'd4, 16'd4, NONE, -1, '0, 3, 1'b0, 1, 0);
        idle(1, 1, 1'b0);

        // Reset with two entries queued, then first arm right after release.
        run_meas('0, '0, NONE, 1, $urandom, -1, 1'b0, 0, 0);
        run_meas('0, '0, NONE, 2, $urandom, -1, 1'b0, 0, 0);
        pulse_reset();
        run_meas('0, '0, NONE, 0, 32'h0000_0003, -1, 1'b0, 1, 0);
        // Reset with a hit latched (FSM in ENCODE): it must not surface.
        step(1'b1, 1'b0, 1'b0, $urandom, '0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, 1'b0, 1'b1, 32'h0000_00FF, '0, 1'b1, 1'b0, 1'b0, '0, 1'b1);
        pulse_reset();
        idle(4, 1, 1'b0);

        // Randomized measurements.
        for (int i = 0; i < 60; i++) begin
            w  = ($urandom_range(0, 3) == 0) ? '0 : CW'($urandom_range(1, 12));
            k  = (w != '0 && $urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 15));
            ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 12)) : -1;
            ae = ($urandom_range(0, 5) == 0);
            case ($urandom_range(0, 2))
                0:       th = $urandom;
                1:       th = 32'hFFFF_FFFF;
                default: th = 32'hFFFF_FFFF >> $urandom_range(1, 32);
            endcase
            run_meas(w, w, NONE, k, th, ab, ae, 2, 2);
            idle($urandom_range(0, 2), 2, 1'b0);
        end
        idle(10, 1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
